wb_arb_rr: RTL
==============

Name: wb_arb_rr

Overview:
- Round-robin Wishbone B3 arbiter placed directly upstream of wb_decode.
- Merges MASTERS flattened master ports into one master-side bus that drives wb_decode's m_* inputs.
- Holds the grant for the whole cycle (m_cyc high) and releases it when that cycle ends.
- A per-grant response watchdog terminates hung slave accesses with an error to the granted master.

Parameters:
- MASTERS, 2: number of masters, 1..8.
- DATA_WIDTH, 32: data width in bits, multiple of 8.
- ADDR_WIDTH, 32: address width in bits.
- TIMEOUT, 255: max cycles a strobe may wait for ack/err/rty; 0 disables the watchdog.
- SEL_WIDTH, DATA_WIDTH>>3 (localparam): byte-select width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m_adr_i  in  ADDR_WIDTH*MASTERS  master addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_dat_i  in  DATA_WIDTH*MASTERS  master write data.
- m_cyc_i, m_stb_i, m_we_i  in  MASTERS each  master cycle, strobe, write enable.
- m_sel_i  in  SEL_WIDTH*MASTERS  byte selects.
- m_cti_i  in  3*MASTERS  cycle type identifiers.
- m_bte_i  in  2*MASTERS  burst type extensions.
- m_dat_o  out  DATA_WIDTH*MASTERS  read data; s_dat_i broadcast to every master slot.
- m_ack_o, m_err_o, m_rty_o  out  MASTERS each  responses; only the granted bit can be 1.
- s_adr_o  out  ADDR_WIDTH  to decoder.
- s_dat_o  out  DATA_WIDTH  to decoder.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to decoder.
- s_sel_o  out  SEL_WIDTH  to decoder.
- s_cti_o  out  3  to decoder.
- s_bte_o  out  2  to decoder.
- s_dat_i  in  DATA_WIDTH  from decoder.
- s_ack_i, s_err_i, s_rty_i  in  1 each  from decoder.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is asynchronous and active-high; asserting it mid-transfer aborts immediately.
- Reset values:
  - state IDLE, grant=0, wd_cnt=0, to_flag=0, last=MASTERS-1 (so master 0 wins first).
  - All s_* outputs 0; m_ack_o, m_err_o, m_rty_o all 0.
- State IDLE:
  - If any m_cyc_i bit is set, pick the first requester searching last+1, last+2, ... modulo MASTERS.
  - Next edge: grant = one-hot pick, last = pick, state GRANT.
  - Latency is exactly 1 cycle from m_cyc_i rising to s_cyc_o rising.
  - No requests: remain IDLE.
- State GRANT (granted index g):
  - s_adr/dat/sel/we/cti/bte_o = master g's fields.
  - s_cyc_o = m_cyc_i[g] & ~to_flag; s_stb_o = m_stb_i[g] & ~to_flag.
  - m_ack_o[g] = s_ack_i; m_rty_o[g] = s_rty_i; m_err_o[g] = s_err_i | to_flag; all other bits 0.
  - When m_cyc_i[g]=0 at an edge: grant=0, state IDLE. This gives exactly one idle cycle between owners, and the next owner is chosen by round robin.
  - Requests from other masters never preempt an active cycle; burst cycles (cti 001/010) stay atomic.
- When grant=0: s_cyc_o = s_stb_o = 0; other s_* outputs = 0.
- Watchdog (TIMEOUT>0):
  - wd_cnt increments each edge while in GRANT with s_stb_o=1 and no ack/err/rty.
  - wd_cnt clears on any response, when s_stb_o=0, or on leaving GRANT.
  - When wd_cnt==TIMEOUT-1 and there is still no response: next edge sets to_flag=1 and clears wd_cnt.
  - to_flag lasts exactly one cycle: it forces m_err_o[g]=1 and masks s_cyc_o/s_stb_o to 0, aborting the slave-side access. It then clears.
  - A response arriving in the same cycle the counter expires wins; no timeout is raised.
- Width rules: wd_cnt width is clog2(TIMEOUT+1); last width is clog2(MASTERS), minimum 1.
- Corner cases:
  - MASTERS=1: grant follows m_cyc_i with the same 1-cycle latency.
  - Master g drops m_cyc_i while its strobe is pending: treated as a release; s_cyc_o falls combinationally in that cycle.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum {ARB_IDLE, ARB_GRANT} arb_state_t.
  - Constants for the CTI burst codes.
  - Reuse clog2 from soc_functions.
- Sub-module wb_arb_rr_pick: combinational round-robin picker. Inputs req[MASTERS] and last; outputs a one-hot pick and its index.

Test Plan:
- MASTERS=3, TIMEOUT=8. Only m_cyc_i[1] and m_stb_i[1] rise at cycle 0 → s_cyc_o=1 and s_adr_o = master1 address at cycle 1. s_ack_i=1 at cycle 2 → m_ack_o=3'b010.
- All three masters request continuously; each drops cyc one cycle after its ack → grant order 0,1,2,0, with exactly one idle cycle between owners.
- Master 0 runs a 4-beat incrementing burst (cti 010, then 111) while master 2 requests → master 2 is granted only after master 0's cyc falls; s_cti_o follows master 0 throughout.
- Master 1 strobes and no slave responds → s_stb_o is high for 8 cycles, then m_err_o=3'b010 for 1 cycle with s_cyc_o=0 in that cycle. A response in cycle 8 instead → ack delivered and no err.
- rst_i asserted mid-burst, asynchronously between edges → all s_* and m_ack/err/rty_o go to 0 immediately. After release, master 0 wins when all three request.
- TIMEOUT=0 with no slave response for 1000 cycles → m_err_o stays 0 and s_stb_o stays high.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

   // Arbiter owner state: nobody owns the bus, or one master holds it.
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Wishbone B3 cycle type identifiers used by bursting masters.
   localparam logic [2:0] CTI_CONST = 3'b001;
   localparam logic [2:0] CTI_INCR  = 3'b010;
   localparam logic [2:0] CTI_END   = 3'b111;

   // Ceiling log2 that never returns less than 1, so counters and
   // indices always have at least one bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module wb_arb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int MASTERS = 2,
   parameter int LAST_W  = 1
) (
   input  logic [MASTERS-1:0] i_req,
   input  logic [LAST_W-1:0]  i_last,
   output logic [MASTERS-1:0] o_pick,
   output logic [LAST_W-1:0]  o_idx
);

   // Search last+1, last+2, ... modulo MASTERS; the first hit wins.
   always_comb begin
      int   cand;
      logic found;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      o_pick = '0;
      o_idx  = '0;
      found  = 1'b0;
      cand   = 0;
      for (int i = 1; i <= MASTERS; i++) begin
         cand = (int'(i_last) + i) % MASTERS;
         for (int k = 0; k < MASTERS; k++) begin
            if (!found && (k == cand) && i_req[k]) begin
               found     = 1'b1;
               o_pick[k] = 1'b1;
               o_idx     = LAST_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone B3 arbiter with a per-grant response watchdog.
// The grant is held for a whole m_cyc cycle, so bursts are never split.
module wb_arb_rr
   import wb_arb_pkg::*;
#(
   parameter int MASTERS    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [ADDR_WIDTH*MASTERS-1:0]  m_adr_i,
   input  logic [DATA_WIDTH*MASTERS-1:0]  m_dat_i,
   input  logic [MASTERS-1:0]             m_cyc_i,
   input  logic [MASTERS-1:0]             m_stb_i,
   input  logic [MASTERS-1:0]             m_we_i,
   input  logic [(DATA_WIDTH/8)*MASTERS-1:0] m_sel_i,
   input  logic [3*MASTERS-1:0]           m_cti_i,
   input  logic [2*MASTERS-1:0]           m_bte_i,
   output logic [DATA_WIDTH*MASTERS-1:0]  m_dat_o,
   output logic [MASTERS-1:0]             m_ack_o,
   output logic [MASTERS-1:0]             m_err_o,
   output logic [MASTERS-1:0]             m_rty_o,
   output logic [ADDR_WIDTH-1:0]          s_adr_o,
   output logic [DATA_WIDTH-1:0]          s_dat_o,
   output logic                           s_cyc_o,
   output logic                           s_stb_o,
   output logic                           s_we_o,
   output logic [DATA_WIDTH/8-1:0]        s_sel_o,
   output logic [2:0]                     s_cti_o,
   output logic [1:0]                     s_bte_o,
   input  logic [DATA_WIDTH-1:0]          s_dat_i,
   input  logic                           s_ack_i,
   input  logic                           s_err_i,
   input  logic                           s_rty_i
);

   localparam int SEL_WIDTH = DATA_WIDTH >> 3;
   localparam int LAST_W    = clog2_min1(MASTERS);
   localparam int WD_W      = clog2_min1(TIMEOUT + 1);
   localparam logic [WD_W-1:0]   WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [LAST_W-1:0] LAST_RST = LAST_W'(MASTERS - 1);

   arb_state_t          r_state,   w_state_nxt;
   logic [MASTERS-1:0]  r_grant,   w_grant_nxt;
   logic [LAST_W-1:0]   r_last,    w_last_nxt;
   logic [WD_W-1:0]     r_wd_cnt,  w_wd_cnt_nxt;
   logic                r_to_flag, w_to_flag_nxt;

   logic [MASTERS-1:0]  w_pick;
   logic [LAST_W-1:0]   w_pick_idx;
   logic                w_cyc_g;
   logic                w_stb_g;
   logic                w_resp;

   wb_arb_rr_pick #(
      .MASTERS (MASTERS),
      .LAST_W  (LAST_W)
   ) u_pick (
      .i_req  (m_cyc_i),
      .i_last (r_last),
      .o_pick (w_pick),
      .o_idx  (w_pick_idx)
   );

   // Route the granted master's request fields to the decoder; all zero when idle.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_cti_o = '0;
      s_bte_o = '0;
      w_cyc_g = 1'b0;
      w_stb_g = 1'b0;
      for (int k = 0; k < MASTERS; k++) begin
         if (r_grant[k]) begin
            s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            s_we_o  = m_we_i[k];
            s_sel_o = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
            s_cti_o = m_cti_i[k*3 +: 3];
            s_bte_o = m_bte_i[k*2 +: 2];
            w_cyc_g = m_cyc_i[k];
            w_stb_g = m_stb_i[k];
         end
      end
   end

   // A timeout cycle masks the slave-side access while the error is returned.
   assign s_cyc_o = w_cyc_g & ~r_to_flag;
   assign s_stb_o = w_stb_g & ~r_to_flag;
   assign w_resp  = s_ack_i | s_err_i | s_rty_i;

   // Responses reach only the granted master; read data is broadcast.
   assign m_ack_o = r_grant & {MASTERS{s_ack_i}};
   assign m_rty_o = r_grant & {MASTERS{s_rty_i}};
   assign m_err_o = r_grant & {MASTERS{s_err_i | r_to_flag}};
   assign m_dat_o = {MASTERS{s_dat_i}};

   // Next-state: grant on request, release on cyc drop, run the watchdog.
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_last_nxt    = r_last;
      w_wd_cnt_nxt  = '0;
      w_to_flag_nxt = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (|m_cyc_i) begin
               w_grant_nxt = w_pick;
               w_last_nxt  = w_pick_idx;
               w_state_nxt = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (!w_cyc_g) begin
               w_grant_nxt = '0;
               w_state_nxt = ARB_IDLE;
            end else if ((TIMEOUT > 0) && s_stb_o && !w_resp) begin
               if (r_wd_cnt == WD_LAST) w_to_flag_nxt = 1'b1;
               else                     w_wd_cnt_nxt  = r_wd_cnt + 1'b1;
            end
         end
         default: begin
            w_grant_nxt = '0;
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // State register; reset aborts any transfer immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ARB_IDLE;
         r_grant   <= '0;
         r_last    <= LAST_RST;
         r_wd_cnt  <= '0;
         r_to_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_last    <= w_last_nxt;
         r_wd_cnt  <= w_wd_cnt_nxt;
         r_to_flag <= w_to_flag_nxt;
      end
   end

endmodule
